// File: rtl/dp_feeder.sv
// dp_feeder: packs LANES-wide operand beats into N_UNIT-wide A/B vectors
// through a two-entry ping-pong buffer and issues one vector per step to
// the dot-product array.
// Optional feature macro: DP_FEEDER_ZERO_SKIP_EN (drop all-zero-A vectors
// that are not the final step and count them in skip_cnt).
module dp_feeder #(
  parameter int N_UNIT  = 32,
  parameter int DW_DATA = 32,
  parameter int LANES   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DW_DATA-1:0]  s_a,
  input  logic [LANES*DW_DATA-1:0]  s_b,
  input  logic                      s_last,
  input  logic                      stall,
  output logic [N_UNIT*DW_DATA-1:0] out_a,
  output logic [N_UNIT*DW_DATA-1:0] out_b,
  output logic [1:0]                out_valid,
  output logic                      out_enable,
  output logic                      busy,
  output logic [15:0]               skip_cnt
);

  localparam int N_BEATS = N_UNIT / LANES;
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int LW      = LANES * DW_DATA;
  localparam int VW      = N_UNIT * DW_DATA;

  logic [BW-1:0]        r_beat_cnt;
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic [1:0]           r_full;
  logic [1:0]           r_last;
  logic [1:0][VW-1:0]   r_buf_a;
  logic [1:0][VW-1:0]   r_buf_b;
  logic [VW-1:0]        r_out_a;
  logic [VW-1:0]        r_out_b;
  logic [1:0]           r_out_valid;

  logic w_accept;
  logic w_last_beat;
  logic w_final;
  logic w_drop;
  logic w_issue;

  assign s_ready     = ~r_full[r_wr_sel];
  assign w_accept    = s_valid & s_ready;
  assign w_last_beat = (r_beat_cnt == BW'(N_BEATS - 1));
  assign w_final     = w_accept & w_last_beat;
  // Issue side only ever reads a full buffer, fill side only a non-full one,
  // so the two never touch the same entry on one edge.
  assign w_issue     = ~stall & r_full[r_rd_sel];

  assign out_a      = r_out_a;
  assign out_b      = r_out_b;
  assign out_valid  = r_out_valid;
  assign out_enable = ~stall;
  assign busy       = (|r_full) | (r_beat_cnt != '0);

`ifdef DP_FEEDER_ZERO_SKIP_EN
  logic        r_aor;
  logic [15:0] r_skip;

  // A completed all-zero-A vector that is not a final step is discarded.
  assign w_drop   = w_final & ~s_last & ~(r_aor | (|s_a));
  assign skip_cnt = r_skip;

  // Running OR of A across the beats of the vector being packed.
  always_ff @(posedge clk) begin
    if (reset)
      r_aor <= 1'b0;
    else if (w_accept)
      r_aor <= w_last_beat ? 1'b0 : (r_aor | (|s_a));
  end

  // Saturating count of dropped vectors.
  always_ff @(posedge clk) begin
    if (reset)
      r_skip <= '0;
    else if (w_drop && (r_skip != 16'hFFFF))
      r_skip <= r_skip + 16'd1;
  end
`else
  assign w_drop   = 1'b0;
  assign skip_cnt = '0;
`endif

  // Beat position within the vector and write-buffer select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= '0;
      r_wr_sel   <= 1'b0;
    end else if (w_accept) begin
      r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      if (w_last_beat && !w_drop)
        r_wr_sel <= ~r_wr_sel;
    end
  end

  // Operand storage: beat k lands in units k*LANES.. of the write buffer.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_a[r_wr_sel][r_beat_cnt*LW +: LW] <= s_a;
      r_buf_b[r_wr_sel][r_beat_cnt*LW +: LW] <= s_b;
    end
  end

  // Full/last flags: set by the fill side, cleared by the issue side.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= '0;
      r_last <= '0;
    end else begin
      if (w_final && !w_drop) begin
        r_full[r_wr_sel] <= 1'b1;
        r_last[r_wr_sel] <= s_last;
      end
      if (w_issue)
        r_full[r_rd_sel] <= 1'b0;
    end
  end

  // Read-buffer select advances on each issue.
  always_ff @(posedge clk) begin
    if (reset)
      r_rd_sel <= 1'b0;
    else if (w_issue)
      r_rd_sel <= ~r_rd_sel;
  end

  // Output registers freeze under stall; operands hold on idle steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_valid <= 2'b00;
    end else if (!stall) begin
      if (w_issue) begin
        r_out_a     <= r_buf_a[r_rd_sel];
        r_out_b     <= r_buf_b[r_rd_sel];
        r_out_valid <= {r_last[r_rd_sel], 1'b1};
      end else begin
        r_out_valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_dp_feeder.sv
// Directed bench for dp_feeder: scoreboard of issued vectors plus
// step-by-step checks of reset, latency, throughput, stall and zero-skip.
module tb_dp_feeder;
  localparam int N_UNIT = 32;
  localparam int DW     = 32;
  localparam int LANES  = 8;
  localparam int NB     = N_UNIT / LANES;
  localparam int LW     = LANES * DW;
  localparam int VW     = N_UNIT * DW;
`ifdef DP_FEEDER_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [LW-1:0] s_a = '0;
  logic [LW-1:0] s_b = '0;
  logic          s_last = 1'b0;
  logic          stall = 1'b0;
  logic [VW-1:0] out_a;
  logic [VW-1:0] out_b;
  logic [1:0]    out_valid;
  logic          out_enable;
  logic          busy;
  logic [15:0]   skip_cnt;

  dp_feeder #(.N_UNIT(N_UNIT), .DW_DATA(DW), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_last(s_last), .stall(stall),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
    .out_enable(out_enable), .busy(busy), .skip_cnt(skip_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [1:0]    v;
  } exp_t;

  exp_t sb[$];
  int   issue_cyc[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   issue_cnt = 0;
  int   ready_drops = 0;
  bit   watch_ready = 1'b0;
  bit   st_e = 1'b1;
  bit   rst_e = 1'b1;
  int   last_acc = 0;
  int   first_acc = 0;
  exp_t e_mon;

  function automatic logic [LW-1:0] mkb(int base, int k);
    logic [LW-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*DW +: DW] = base + k*LANES + j;
    return r;
  endfunction

  function automatic logic [VW-1:0] mkv(int base);
    logic [VW-1:0] r;
    for (int i = 0; i < N_UNIT; i++) r[i*DW +: DW] = base + i;
    return r;
  endfunction

  function automatic int first_diff(logic [VW-1:0] x, logic [VW-1:0] y);
    for (int i = 0; i < N_UNIT; i++)
      if (x[i*DW +: DW] !== y[i*DW +: DW]) return i;
    return 0;
  endfunction

  function automatic int ic(int idx);
    return (idx >= 0 && idx < issue_cyc.size()) ? issue_cyc[idx] : -1;
  endfunction

  // Edge-time view of stall/reset and a cycle counter.
  always @(posedge clk) begin
    cyc++;
    st_e  = stall;
    rst_e = reset;
  end

  // Issue monitor: every new step popped against the scoreboard.
  always @(negedge clk) begin
    if (watch_ready && s_valid && !s_ready) ready_drops++;
    if (!rst_e && !st_e && out_valid != 2'b00) begin
      issue_cnt++;
      issue_cyc.push_back(cyc);
      nchk++;
      assert (sb.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_issue: observed out_valid=%b, required no issue", out_valid);
      end
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        nchk++;
        assert (out_valid === e_mon.v) else begin
          nerr++;
          $error("FAIL issue_valid: observed %b, required %b", out_valid, e_mon.v);
        end
        nchk++;
        assert (out_a === e_mon.a) else begin
          nerr++;
          $error("FAIL issue_a: unit %0d observed %h, required %h", first_diff(out_a, e_mon.a),
                 out_a[first_diff(out_a, e_mon.a)*DW +: DW], e_mon.a[first_diff(out_a, e_mon.a)*DW +: DW]);
        end
        nchk++;
        assert (out_b === e_mon.b) else begin
          nerr++;
          $error("FAIL issue_b: unit %0d observed %h, required %h", first_diff(out_b, e_mon.b),
                 out_b[first_diff(out_b, e_mon.b)*DW +: DW], e_mon.b[first_diff(out_b, e_mon.b)*DW +: DW]);
        end
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
    int u;
    u = first_diff(obs, exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: unit %0d observed %h, required %h", tag, u, obs[u*DW +: DW], exp[u*DW +: DW]);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
  endtask

  // Present one beat and wait (bounded) for its handshake edge.
  task automatic send_beat(logic [LW-1:0] a, logic [LW-1:0] b, logic last);
    bit done;
    done = 1'b0;
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
    end
    chk("beat_accept_timeout", done, 1);
    last_acc = cyc;
  endtask

  task automatic send_vec(int ba, int bb, bit last, bit zero_a);
    exp_t e;
    for (int k = 0; k < NB; k++) begin
      if (k == NB-1 && !(SKIP && zero_a && !last)) begin
        e.a = zero_a ? '0 : mkv(ba);
        e.b = mkv(bb);
        e.v = {last, 1'b1};
        sb.push_back(e);
      end
      send_beat(zero_a ? '0 : mkb(ba, k), mkb(bb, k), (k == NB-1) ? last : 1'b0);
      if (k == 0) first_acc = last_acc;
    end
  endtask

  initial begin
    int e0, i0, rel;
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    chk("rst_out_valid", out_valid, 2'b00);
    chkv("rst_out_a", out_a, '0);
    chkv("rst_out_b", out_b, '0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_skip_cnt", skip_cnt, 0);
    chk("rst_out_enable", out_enable, 1);
    @(posedge clk); #1;

    // Single vector: latency and one issue
    send_vec(1, 100, 1'b0, 1'b0);
    e0 = last_acc;
    idle();
    settle();
    settle();
    chk("lat_out_valid", out_valid, 2'b01);
    chk("lat_issue_cycle", ic(0), e0 + 1);
    repeat (3) settle();
    chk("single_issue_cnt", issue_cnt, 1);
    chk("idle_out_valid", out_valid, 2'b00);
    chkv("idle_out_a_hold", out_a, mkv(1));
    @(posedge clk); #1;

    // Three back-to-back vectors
    i0 = issue_cnt;
    watch_ready = 1'b1;
    send_vec(40, 200, 1'b0, 1'b0);
    send_vec(80, 300, 1'b0, 1'b0);
    send_vec(120, 400, 1'b1, 1'b0);
    idle();
    watch_ready = 1'b0;
    repeat (4) settle();
    chk("stream_ready_drops", ready_drops, 0);
    chk("stream_issue_cnt", issue_cnt, i0 + 3);
    chk("stream_gap_1", ic(i0+1) - ic(i0), 4);
    chk("stream_gap_2", ic(i0+2) - ic(i0+1), 4);
    @(posedge clk); #1;

    // Stall while filling both buffers
    i0 = issue_cnt;
    stall = 1'b1;
    send_vec(500, 600, 1'b0, 1'b0);
    send_vec(700, 800, 1'b0, 1'b0);
    idle();
    repeat (3) settle();
    chk("stall_s_ready", s_ready, 0);
    chk("stall_out_enable", out_enable, 0);
    chk("stall_busy", busy, 1);
    chk("stall_out_valid", out_valid, 2'b00);
    chkv("stall_out_a_frozen", out_a, mkv(120));
    chk("stall_no_issue", issue_cnt, i0);
    @(posedge clk); #1;
    stall = 1'b0;
    rel = cyc;
    send_vec(900, 1000, 1'b1, 1'b0);
    idle();
    repeat (4) settle();
    chk("release_issue1", ic(i0), rel + 1);
    chk("release_issue2", ic(i0+1), rel + 2);
    chk("release_third_accept", first_acc, rel + 2);
    chk("release_issue_cnt", issue_cnt, i0 + 3);
    @(posedge clk); #1;

    // Reset in the middle of a vector
    send_beat(mkb(1111, 0), mkb(2222, 0), 1'b0);
    send_beat(mkb(1111, 1), mkb(2222, 1), 1'b0);
    idle();
    settle();
    chk("partial_busy", busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    stall = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stall = 1'b0;
    settle();
    chk("mid_rst_out_valid", out_valid, 2'b00);
    chkv("mid_rst_out_a", out_a, '0);
    chkv("mid_rst_out_b", out_b, '0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    @(posedge clk); #1;
    i0 = issue_cnt;
    send_vec(1300, 1400, 1'b0, 1'b0);
    idle();
    repeat (3) settle();
    chk("post_rst_issue_cnt", issue_cnt, i0 + 1);
    @(posedge clk); #1;

    // Zero-A vectors
    i0 = issue_cnt;
    send_vec(0, 1500, 1'b0, 1'b1);
    send_vec(0, 1600, 1'b1, 1'b1);
    idle();
    repeat (6) settle();
    chk("zero_skip_cnt", skip_cnt, SKIP ? 1 : 0);
    chk("zero_issue_cnt", issue_cnt, i0 + (SKIP ? 1 : 2));
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dp_feeder.md
# dp_feeder

Operand transmitter for the dot-product array: packs a narrow lane stream of A/B operands into full N_UNIT-wide vectors and issues them, one vector per step, on the array's operand interface (`in_a`, `in_b`, `in_valid`, `enable`). A two-entry ping-pong buffer lets the next vector be assembled while the current one is issued. The block sits between the operand fetch path and the dp_group array.

## Interface
- `N_UNIT`, 32: dot-product units per array; must be a multiple of `LANES`.
- `DW_DATA`, 32: bits per operand element.
- `LANES`, 8: elements per input beat; `N_BEATS = N_UNIT/LANES`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `s_valid` input 1: input beat valid.
- `s_ready` output 1: input beat accepted when `s_valid & s_ready`.
- `s_a` input LANES*DW_DATA: A elements for this beat, lane 0 in the LSBs.
- `s_b` input LANES*DW_DATA: B elements for this beat.
- `s_last` input 1: the vector being packed is the final step of its dot product; sampled on the vector's final beat only.
- `stall` input 1: downstream hold request.
- `out_a` output N_UNIT*DW_DATA: to array `in_a`.
- `out_b` output N_UNIT*DW_DATA: to array `in_b`.
- `out_valid` output 2: to array `in_valid`; 2'b00 = no step, 2'b01 = accumulate, 2'b11 = accumulate and last step; 2'b10 is never driven.
- `out_enable` output 1: to array `enable`; equals `~stall`, combinational.
- `busy` output 1: high while any buffer is full or a partial vector is in progress.
- `skip_cnt` output 16: count of vectors dropped by zero-skip; saturates at 16'hFFFF.

## Operation
- Beat counter `beat_cnt` runs 0..N_BEATS-1 and wraps to 0 after the final beat. Beat k is written to units k*LANES .. k*LANES+LANES-1 of buffer `wr_sel`.
- Each buffer has a full flag and a stored last flag. `s_ready = ~full[wr_sel]`.
- When the final beat is accepted, `full[wr_sel]` is set, `s_last` is stored, and `wr_sel` toggles.
- Issue takes place on an edge where `~stall & full[rd_sel]`. On that edge:
  - `out_a`/`out_b` load the buffer contents.
  - `out_valid` loads `{last, 1'b1}`.
  - `full[rd_sel]` clears and `rd_sel` toggles.
- An edge with `~stall` and no full buffer loads `out_valid` = 2'b00. `out_a` and `out_b` hold their values.
- When `stall` is high, every output register holds and no issue occurs. Input packing continues while a buffer is free.
- The fill side and the issue side never address the same buffer on the same edge, because the fill side is gated by `full[wr_sel]`.
- All arithmetic is on counters only. Operands pass through bit-exact; signedness is not interpreted.

## Timing
- Reset values:
  - `out_a`, `out_b`: 0.
  - `out_valid`: 2'b00.
  - `skip_cnt`: 0; `busy`: 0.
  - `beat_cnt`, `wr_sel`, `rd_sel`: 0.
  - Full flags: cleared.
  - `s_ready` is 1 on the first cycle after reset deasserts.
- Reset mid-operation discards the partial vector and both buffers with no issue. `stall` is ignored during reset.
- Latency: a final beat accepted at edge E gives `out_valid` != 0 after edge E+1 when `stall` is low.
- Throughput: one vector per max(N_BEATS, 1) cycles with no stall. With N_BEATS=1, input can be accepted every cycle.
- Backpressure: with both buffers full, `s_ready` is 0 until the next issue edge. `s_ready` rises on the cycle after that edge.

## Configuration
- `DP_FEEDER_ZERO_SKIP_EN` defined:
  - A running OR of all `s_a` lanes is tracked per vector.
  - A completed vector whose A is all zero and whose `s_last` = 0 is dropped: no full flag is set, `wr_sel` does not toggle, and `skip_cnt` increments.
  - An all-zero vector with `s_last` = 1 is still issued, so the last marker is delivered.
- Macro undefined: every vector is issued and `skip_cnt` is tied to 0.

## Test plan
- Defaults (N_BEATS=4). Send 4 beats with lane values 1..32 in A, 100..131 in B, and `s_last`=0. Required: `out_valid`=2'b01 after edge E+1 of the final beat; `out_a` unit i = i+1; one issue only.
- Stream 3 back-to-back vectors, the third with `s_last`=1. Required: `out_valid` sequence 01, 01, 11; `s_ready` never drops; each vector issued 4 cycles apart.
- Hold `stall`=1 while sending 3 vectors. Required: `s_ready` drops after 2 vectors are complete; `out_enable`=0; outputs frozen. Release `stall`: the 2 vectors issue on consecutive edges, then the third is accepted.
- Assert `reset` for 1 cycle after 2 beats of a vector. Required: all outputs return to reset values; the next 4 beats form a fresh vector aligned at unit 0.
- With `DP_FEEDER_ZERO_SKIP_EN`, send an all-zero-A vector with `s_last`=0, then one with `s_last`=1. Required: `skip_cnt`=1; only one issue, with `out_valid`=2'b11.
- Without the macro, repeat the previous scenario. Required: two issues (01 then 11) and `skip_cnt`=0.
